// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests 64-byte lines over the Sysbus, packs the beats into a
// circular byte buffer and presents the decoder with a 15-byte window at dec_pc.
module fetch_unit #(
  parameter int TAGW      = 13,
  parameter int BUF_BYTES = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     entry,
  output logic            reqcyc,
  output logic [63:0]     req,
  output logic [TAGW-1:0] reqtag,
  input  logic            reqack,
  input  logic            respcyc,
  input  logic [63:0]     resp,
  output logic            respack,
  input  logic            redirect,
  input  logic [63:0]     redirect_pc,
  output logic [119:0]    dec_bytes,
  output logic [63:0]     dec_pc,
  output logic [7:0]      dec_avail,
  output logic            dec_valid,
  input  logic [3:0]      dec_consume
);

  localparam int              PW            = $clog2(BUF_BYTES);
  localparam logic [7:0]      ISSUE_MAX     = 8'(BUF_BYTES - 64);
  localparam logic            SYSBUS_READ   = 1'b1;
  localparam logic [3:0]      SYSBUS_MEMORY = 4'b0001;
  localparam logic [TAGW-1:0] READ_TAG      = TAGW'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t          state_r;
  logic [63:0]     fetch_line_r;
  logic [63:0]     req_r;
  logic [63:0]     dec_pc_r;
  logic [5:0]      skip_r;
  logic [2:0]      beat_cnt_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [7:0]      occ_r;
  logic            reqcyc_r;
  logic            dec_valid_r;
  logic [7:0]      buf_r [BUF_BYTES];

  logic [5:0]      beat_base_s;
  logic [5:0]      skip_gap_s;
  logic [3:0]      drop_s;
  logic            beat_s;
  logic            wr_en_s;
  logic            line_end_s;
  logic [3:0]      wr_cnt_s;
  logic [3:0]      cons_s;
  logic [7:0]      occ_next_s;
  logic            issue_ok_s;
  logic [119:0]    window_s;

  assign beat_base_s = {beat_cnt_r, 3'b000};

  // Number of leading bytes of the current beat that fall below the skip offset.
  always_comb begin
    skip_gap_s = 6'd0;
    drop_s     = 4'd0;
    if (skip_r > beat_base_s) begin
      skip_gap_s = skip_r - beat_base_s;
      if (skip_gap_s >= 6'd8) begin
        drop_s = 4'd8;
      end else begin
        drop_s = skip_gap_s[3:0];
      end
    end else begin
      drop_s = 4'd0;
    end
  end

  // Beats are counted in every non-idle state so a drain always finds the stale line's end.
  assign beat_s     = respcyc && (state_r != ST_IDLE);
  assign wr_en_s    = beat_s && !redirect && ((state_r == ST_WAIT) || (state_r == ST_ACTIVE));
  assign line_end_s = beat_s && (beat_cnt_r == 3'd7);
  assign wr_cnt_s   = wr_en_s ? (4'd8 - drop_s) : 4'd0;
  assign cons_s     = (dec_valid_r && !redirect) ? dec_consume : 4'd0;
  assign occ_next_s = occ_r + {4'd0, wr_cnt_s} - {4'd0, cons_s};
  assign issue_ok_s = (occ_r <= ISSUE_MAX);

  // Window gather from the read pointer; the index wraps by truncation.
  always_comb begin
    window_s = 120'd0;
    for (int i = 0; i < 15; i++) begin
      window_s[119 - 8*i -: 8] = buf_r[rd_ptr_r + PW'(i)];
    end
  end

  // Byte buffer: kept bytes of a beat are packed contiguously at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < BUF_BYTES; j++) begin
        buf_r[j] <= 8'h00;
      end
    end else if (wr_en_s) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) >= drop_s) begin
          buf_r[wr_ptr_r + PW'(k) - PW'(drop_s)] <= resp[8*k +: 8];
        end
      end
    end
  end

  // Pointers, occupancy and decoder-facing state; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= 8'd0;
      dec_pc_r    <= entry;
      dec_valid_r <= 1'b0;
    end else if (redirect) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= 8'd0;
      dec_pc_r    <= redirect_pc;
      dec_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_r + PW'(wr_cnt_s);
      rd_ptr_r    <= rd_ptr_r + PW'(cons_s);
      occ_r       <= occ_next_s;
      dec_pc_r    <= dec_pc_r + {60'd0, cons_s};
      dec_valid_r <= (occ_next_s >= 8'd15);
    end
  end

  // Request/response sequencing and the next-line target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      fetch_line_r <= {entry[63:6], 6'b000000};
      skip_r       <= entry[5:0];
      beat_cnt_r   <= 3'd0;
      reqcyc_r     <= 1'b0;
      req_r        <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (redirect) begin
            reqcyc_r <= 1'b0;
            state_r  <= (reqcyc_r && reqack) ? ST_DRAIN : ST_IDLE;
          end else if (reqcyc_r) begin
            if (reqack) begin
              reqcyc_r <= 1'b0;
              state_r  <= ST_WAIT;
            end
          end else if (issue_ok_s) begin
            reqcyc_r <= 1'b1;
            req_r    <= fetch_line_r;
          end
        end
        ST_WAIT, ST_ACTIVE: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 3'd1;
          end
          // A redirect on the final beat has nothing left to drain.
          if (redirect) begin
            state_r <= line_end_s ? ST_IDLE : ST_DRAIN;
          end else if (line_end_s) begin
            state_r      <= ST_IDLE;
            fetch_line_r <= fetch_line_r + 64'd64;
            skip_r       <= 6'd0;
          end else if (beat_s) begin
            state_r <= ST_ACTIVE;
          end
        end
        ST_DRAIN: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 3'd1;
            if (line_end_s) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (redirect) begin
        fetch_line_r <= {redirect_pc[63:6], 6'b000000};
        skip_r       <= redirect_pc[5:0];
      end
    end
  end

  assign reqcyc    = reqcyc_r;
  assign req       = req_r;
  assign reqtag    = READ_TAG;
  assign respack   = respcyc;
  assign dec_bytes = window_s;
  assign dec_pc    = dec_pc_r;
  assign dec_avail = occ_r;
  assign dec_valid = dec_valid_r;

  // Beats are only legal while a line is outstanding or being drained.
  a_no_beat_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(respcyc && (state_r == ST_IDLE)))
    else $fatal(1, "fetch_unit: respcyc while idle");

endmodule
